// File: rtl/uart_cmd_parser.sv
// Frame parser behind the UART receiver: SYNC, CMD, LEN, payload, CHK (XOR) framing,
// with a separate output holding register presented over a valid/ready handshake.
module uart_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 8,
  parameter int         TIMEOUT_CYCLES = 100_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [7:0]           cmd_code,
  output logic [3:0]           cmd_len,
  output logic [8*MAX_LEN-1:0] cmd_payload,
  output logic                 busy,
  output logic                 err_checksum,
  output logic                 err_length,
  output logic                 err_timeout,
  output logic                 err_overrun
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] HUNT    = 3'd0;
  localparam logic [2:0] GET_CMD = 3'd1;
  localparam logic [2:0] GET_LEN = 3'd2;
  localparam logic [2:0] GET_PAY = 3'd3;
  localparam logic [2:0] GET_CHK = 3'd4;

  logic [2:0]           state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [3:0]           idx_reg, idx_next;
  logic [3:0]           len_reg, len_next;
  logic [7:0]           code_reg, code_next;
  logic [7:0]           chk_reg, chk_next;
  logic [8*MAX_LEN-1:0] buf_reg, buf_next;
  logic                 deliver, bad_len, bad_chk, expire;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    len_next   = len_reg;
    code_next  = code_reg;
    chk_next   = chk_reg;
    buf_next   = buf_reg;
    deliver    = 1'b0;
    bad_len    = 1'b0;
    bad_chk    = 1'b0;
    expire     = 1'b0;

    if (rx_valid) begin
      // A byte arriving on the expiry cycle is processed; the timeout never fires then.
      cnt_next = '0;
      case (state_reg)
        HUNT: begin
          if (rx_data == SYNC_BYTE) begin
            state_next = GET_CMD;
            buf_next   = '0;
          end
        end
        GET_CMD: begin
          code_next  = rx_data;
          chk_next   = rx_data;
          state_next = GET_LEN;
        end
        GET_LEN: begin
          chk_next = chk_reg ^ rx_data;
          len_next = rx_data[3:0];
          idx_next = 4'd0;
          if (rx_data > 8'(MAX_LEN)) begin
            bad_len    = 1'b1;
            state_next = HUNT;
          end else if (rx_data == 8'd0) begin
            state_next = GET_CHK;
          end else begin
            state_next = GET_PAY;
          end
        end
        GET_PAY: begin
          for (int i = 0; i < MAX_LEN; i++) begin
            if (idx_reg == 4'(i)) buf_next[8*i +: 8] = rx_data;
          end
          chk_next = chk_reg ^ rx_data;
          idx_next = idx_reg + 4'd1;
          if (idx_reg == len_reg - 4'd1) state_next = GET_CHK;
        end
        GET_CHK: begin
          state_next = HUNT;
          if (rx_data == chk_reg) deliver = 1'b1;
          else                    bad_chk = 1'b1;
        end
        default: state_next = HUNT;
      endcase
    end else if (state_reg == HUNT) begin
      cnt_next = '0;
    end else if (cnt_reg == CW'(TIMEOUT_CYCLES)) begin
      expire     = 1'b1;
      state_next = HUNT;
      cnt_next   = '0;
    end else if (cnt_reg != '1) begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= HUNT;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      len_reg      <= '0;
      code_reg     <= '0;
      chk_reg      <= '0;
      buf_reg      <= '0;
      cmd_valid    <= 1'b0;
      cmd_code     <= '0;
      cmd_len      <= '0;
      cmd_payload  <= '0;
      busy         <= 1'b0;
      err_checksum <= 1'b0;
      err_length   <= 1'b0;
      err_timeout  <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      len_reg      <= len_next;
      code_reg     <= code_next;
      chk_reg      <= chk_next;
      buf_reg      <= buf_next;
      busy         <= (state_next != HUNT);
      err_checksum <= bad_chk;
      err_length   <= bad_len;
      err_timeout  <= expire;
      err_overrun  <= deliver && cmd_valid && !cmd_ready;
      // A consume and a new load on the same edge keep cmd_valid high.
      if (deliver && (!cmd_valid || cmd_ready)) begin
        cmd_valid   <= 1'b1;
        cmd_code    <= code_reg;
        cmd_len     <= len_reg;
        cmd_payload <= buf_reg;
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

endmodule
